// File: rtl/sdram_arbit_if.sv
// Command-bus bundle between the SDRAM sub-controllers, the arbiter and the SDRAM pins.
// slave modport is the arbiter view; master modport is the requester/pin-side view.
// Pure wiring, no logic.
interface sdram_arbit_if #(
  parameter int ADDR_W = 12,
  parameter int BANK_W = 2
);
  // init sequencer
  logic              init_end;
  logic [3:0]        init_cmd;
  logic [BANK_W-1:0] init_ba;
  logic [ADDR_W-1:0] init_addr;
  // auto-refresh
  logic              aref_req;
  logic              aref_end;
  logic [3:0]        aref_cmd;
  logic [ADDR_W-1:0] aref_addr;
  logic              aref_en;
  // write
  logic              wr_req;
  logic              wr_end;
  logic [3:0]        wr_cmd;
  logic [BANK_W-1:0] wr_ba;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  // read
  logic              rd_req;
  logic              rd_end;
  logic [3:0]        rd_cmd;
  logic [BANK_W-1:0] rd_ba;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  // SDRAM command/address pins
  logic              sdram_cke;
  logic              sdram_cs_n;
  logic              sdram_ras_n;
  logic              sdram_cas_n;
  logic              sdram_we_n;
  logic [BANK_W-1:0] sdram_bank;
  logic [ADDR_W-1:0] sdram_addr;

  modport slave (
    input  init_end, init_cmd, init_ba, init_addr,
    input  aref_req, aref_end, aref_cmd, aref_addr,
    input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr,
    input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    output aref_en, wr_en, rd_en,
    output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    output sdram_bank, sdram_addr
  );

  modport master (
    output init_end, init_cmd, init_ba, init_addr,
    output aref_req, aref_end, aref_cmd, aref_addr,
    output wr_req, wr_end, wr_cmd, wr_ba, wr_addr,
    output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    input  aref_en, wr_en, rd_en,
    input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    input  sdram_bank, sdram_addr
  );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: init pass-through, then one of refresh/write/read owns the pins.
// Latency: grant registered on the edge a request is seen in ARBIT; pins mux combinationally from state.
// Backpressure: requests are levels held until granted; an op ends only on its own *_end pulse.
module sdram_arbit #(
  parameter int RW_ALT = 1,
  parameter int ADDR_W = 12,
  parameter int BANK_W = 2
) (
  input logic          sclk,
  input logic          srst_n,
  sdram_arbit_if.slave bus
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_ARBIT = 3'd1,
    S_AREF  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } state_t;

  localparam logic [3:0] CMD_NOP = 4'b0111;

  state_t state_q, state_d;
  logic   aref_en_q, aref_en_d;
  logic   wr_en_q, wr_en_d;
  logic   rd_en_q, rd_en_d;
  // 1 = write was the last read/write op served; reset to "read" so write wins the first contest
  logic   last_wr_q, last_wr_d;
  logic   pick_wr;

  logic [3:0]        cmd;
  logic [BANK_W-1:0] bank;
  logic [ADDR_W-1:0] addr;

  // Write/read tie-break: alternate when RW_ALT is set, otherwise write always wins
  assign pick_wr = (RW_ALT != 0) ? ~last_wr_q : 1'b1;

  // State, grant and round-robin history registers
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state_q   <= S_INIT;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      last_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      aref_en_q <= aref_en_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      last_wr_q <= last_wr_d;
    end
  end

  // Next-state and grant decisions; every op returns through ARBIT so ops are NOP-separated
  always_comb begin
    state_d   = state_q;
    aref_en_d = aref_en_q;
    wr_en_d   = wr_en_q;
    rd_en_d   = rd_en_q;
    last_wr_d = last_wr_q;
    unique case (state_q)
      S_INIT: begin
        if (bus.init_end) state_d = S_ARBIT;
      end
      S_ARBIT: begin
        if (bus.aref_req) begin
          state_d   = S_AREF;
          aref_en_d = 1'b1;
        end else if (bus.wr_req && bus.rd_req) begin
          if (pick_wr) begin
            state_d = S_WRITE;
            wr_en_d = 1'b1;
          end else begin
            state_d = S_READ;
            rd_en_d = 1'b1;
          end
        end else if (bus.wr_req) begin
          state_d = S_WRITE;
          wr_en_d = 1'b1;
        end else if (bus.rd_req) begin
          state_d = S_READ;
          rd_en_d = 1'b1;
        end
      end
      S_AREF: begin
        if (bus.aref_end) begin
          state_d   = S_ARBIT;
          aref_en_d = 1'b0;
        end
      end
      S_WRITE: begin
        if (bus.wr_end) begin
          state_d   = S_ARBIT;
          wr_en_d   = 1'b0;
          last_wr_d = 1'b1;
        end
      end
      S_READ: begin
        if (bus.rd_end) begin
          state_d   = S_ARBIT;
          rd_en_d   = 1'b0;
          last_wr_d = 1'b0;
        end
      end
      default: begin
        state_d   = S_INIT;
        aref_en_d = 1'b0;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
      end
    endcase
  end

  // Pin mux keyed on the registered owner; ARBIT and refresh drive bank 0
  always_comb begin
    cmd  = CMD_NOP;
    bank = '0;
    addr = '0;
    unique case (state_q)
      S_INIT: begin
        cmd  = bus.init_cmd;
        bank = bus.init_ba;
        addr = bus.init_addr;
      end
      S_AREF: begin
        cmd  = bus.aref_cmd;
        addr = bus.aref_addr;
      end
      S_WRITE: begin
        cmd  = bus.wr_cmd;
        bank = bus.wr_ba;
        addr = bus.wr_addr;
      end
      S_READ: begin
        cmd  = bus.rd_cmd;
        bank = bus.rd_ba;
        addr = bus.rd_addr;
      end
      default: begin
        cmd  = CMD_NOP;
        bank = '0;
        addr = '0;
      end
    endcase
  end

  // Clock enable follows reset directly so it drops the instant reset asserts
  assign bus.sdram_cke = srst_n;
  assign {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} = cmd;
  assign bus.sdram_bank = bank;
  assign bus.sdram_addr = addr;
  assign bus.aref_en    = aref_en_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.rd_en      = rd_en_q;

endmodule
